// File: rtl/alarm_sched_if.sv
// rtl/alarm_sched_if.sv - request/grant bundle between the vital-sign alarm sources and the alarm scheduler
//
// Purpose: groups the scheduler's control inputs and its registered grant/alarm outputs.
// Signals:
//   sw      post-op monitoring enable
//   req     [2:0] level alarm requests (0 = heart rate, 1 = SpO2, 2 = temperature)
//   tick    one-cycle time-base strobe
//   clear0  operator acknowledge
//   grant   [2:0] one-hot channel currently shown
//   alarm   one-cycle pulse on each new grant
//   history one-cycle pulse with alarm when the channel re-alarmed inside its window
//   buzz    high for the whole SHOW period of a grant that raised history
// Modports: master drives the inputs (environment), slave is the scheduler.
interface alarm_sched_if;
    logic       sw;
    logic [2:0] req;
    logic       tick;
    logic       clear0;
    logic [2:0] grant;
    logic       alarm;
    logic       history;
    logic       buzz;

    modport master (
        output sw, req, tick, clear0,
        input  grant, alarm, history, buzz
    );

    modport slave (
        input  sw, req, tick, clear0,
        output grant, alarm, history, buzz
    );
endinterface

// File: rtl/alarm_sched.sv
// rtl/alarm_sched.sv - three-channel vital-sign alarm scheduler with hold time and re-alarm history
//
// Purpose: picks one pending alarm channel, shows it for HOLD_TICKS ticks (or until
// acknowledged), inserts a one-cycle gap, and flags re-alarms of a channel that occur
// within HIST_WIN ticks of that channel's previous grant.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  alarm_sched_if.slave (sw, req, tick, clear0 in; grant, alarm, history, buzz out)
// Parameters:
//   HOLD_TICKS  ticks a granted alarm is shown (1..255)
//   HIST_WIN    history window length in ticks (1..255)
// Build option:
//   ALARM_SCHED_FIXED_PRIO_EN  fixed priority arbitration (bit 0 highest) instead of round-robin
module alarm_sched #(
    parameter int HOLD_TICKS = 4,
    parameter int HIST_WIN   = 10
) (
    input  logic          clk,
    input  logic          rst,
    alarm_sched_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, SCAN, SHOW, GAP} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_TICKS - 1);
    localparam logic [7:0] HIST_LOAD = 8'(HIST_WIN);

    state_t     state_q, state_d;
    logic [1:0] win_q;
    logic [1:0] win_sel;
    logic [7:0] hold_q;
    logic [7:0] timer_q [3];
    logic       show_end;
    logic       take;

    logic [2:0] grant_q, grant_d;
    logic       alarm_q, alarm_d;
    logic       history_q, history_d;
    logic       buzz_q, buzz_d;

    function automatic logic [1:0] inc3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] x);
        logic [2:0] v;
        v = 3'b000;
        v[x] = 1'b1;
        return v;
    endfunction

    // clear0 wins over tick; both only matter while showing
    assign show_end = (state_q == SHOW) &&
                      (bus.clear0 || (bus.tick && hold_q == HOLD_LAST));
    assign take     = bus.sw && (state_q == SCAN) && (bus.req != 3'b000);

`ifdef ALARM_SCHED_FIXED_PRIO_EN
    always_comb begin
        win_sel = 2'd0;
        if (bus.req[0])      win_sel = 2'd0;
        else if (bus.req[1]) win_sel = 2'd1;
        else if (bus.req[2]) win_sel = 2'd2;
    end
`else
    logic [1:0] p_q;
    logic [1:0] cand1, cand2;

    assign cand1 = inc3(p_q);
    assign cand2 = inc3(cand1);

    // Later assignments override earlier ones, so the search order is p, p+1, p+2.
    always_comb begin
        win_sel = 2'd0;
        if (bus.req[cand2]) win_sel = cand2;
        if (bus.req[cand1]) win_sel = cand1;
        if (bus.req[p_q])   win_sel = p_q;
    end

    always_ff @(posedge clk) begin
        if (rst || !bus.sw) begin
            p_q <= 2'd0;
        end else if (state_q == GAP) begin
            p_q <= inc3(win_q);
        end
    end
`endif

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= 3'b000;
            alarm_q   <= 1'b0;
            history_q <= 1'b0;
            buzz_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            alarm_q   <= alarm_d;
            history_q <= history_d;
            buzz_q    <= buzz_d;
        end
    end

    // Next-state logic; dropping sw overrides everything
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.sw) state_d = SCAN;
            SCAN:    if (bus.req != 3'b000) state_d = SHOW;
            SHOW:    if (show_end) state_d = GAP;
            GAP:     state_d = SCAN;
            default: state_d = IDLE;
        endcase
        if (!bus.sw) state_d = IDLE;
    end

    // Next values of the registered outputs
    always_comb begin
        grant_d   = 3'b000;
        alarm_d   = 1'b0;
        history_d = 1'b0;
        buzz_d    = 1'b0;
        if (take) begin
            grant_d   = onehot(win_sel);
            alarm_d   = 1'b1;
            history_d = (timer_q[win_sel] != 8'd0);
            buzz_d    = (timer_q[win_sel] != 8'd0);
        end else if (bus.sw && state_q == SHOW && !show_end) begin
            grant_d = grant_q;
            buzz_d  = buzz_q;
        end
    end

    // Datapath: winner, hold counter, per-channel history timers
    always_ff @(posedge clk) begin
        if (rst) begin
            win_q  <= 2'd0;
            hold_q <= 8'd0;
            for (int i = 0; i < 3; i++) timer_q[i] <= 8'd0;
        end else begin
            if (take) win_q <= win_sel;

            if (bus.sw && state_q == SHOW && !show_end) begin
                if (bus.tick) hold_q <= hold_q + 8'd1;
            end else begin
                hold_q <= 8'd0;
            end

            for (int i = 0; i < 3; i++) begin
                if (!bus.sw) begin
                    timer_q[i] <= 8'd0;
                end else if (state_q == GAP && win_q == 2'(i)) begin
                    // the load wins over a coincident tick
                    timer_q[i] <= HIST_LOAD;
                end else if (bus.tick && timer_q[i] != 8'd0) begin
                    timer_q[i] <= timer_q[i] - 8'd1;
                end
            end
        end
    end

    assign bus.grant   = grant_q;
    assign bus.alarm   = alarm_q;
    assign bus.history = history_q;
    assign bus.buzz    = buzz_q;

endmodule

// File: tb/tb_alarm_sched.sv
// tb/tb_alarm_sched.sv - directed self-checking bench for alarm_sched (default and HIST_WIN=2 instances)
module tb_alarm_sched;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    alarm_sched_if a ();
    alarm_sched_if b ();

    alarm_sched u0 (
        .clk (clk),
        .rst (rst),
        .bus (a.slave)
    );

    alarm_sched #(.HOLD_TICKS(4), .HIST_WIN(2)) u1 (
        .clk (clk),
        .rst (rst),
        .bus (b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // obs = {grant, alarm, history, buzz}
    task automatic outs(input string tag, input logic [5:0] obs,
                        input logic [2:0] g, input logic al, input logic h, input logic bz);
        chk({tag, ".grant"},   8'(obs[5:3]), 8'(g));
        chk({tag, ".alarm"},   8'(obs[2]),   8'(al));
        chk({tag, ".history"}, 8'(obs[1]),   8'(h));
        chk({tag, ".buzz"},    8'(obs[0]),   8'(bz));
    endtask

    // each tick is one strobe cycle followed by one quiet cycle
    task automatic tick_a(input int n);
        for (int i = 0; i < n; i++) begin
            a.tick = 1'b1; step();
            a.tick = 1'b0; step();
        end
    endtask

    task automatic tick_b(input int n);
        for (int i = 0; i < n; i++) begin
            b.tick = 1'b1; step();
            b.tick = 1'b0; step();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        a.sw = 1'b0; a.req = 3'b000; a.tick = 1'b0; a.clear0 = 1'b0;
        b.sw = 1'b0; b.req = 3'b000; b.tick = 1'b0; b.clear0 = 1'b0;

        step();
        outs("reset_a", {a.grant, a.alarm, a.history, a.buzz}, 3'b000, 0, 0, 0);
        outs("reset_b", {b.grant, b.alarm, b.history, b.buzz}, 3'b000, 0, 0, 0);

        // single channel held: grant, hold 4 ticks, gap, re-grant with history
        rst = 1'b0; a.sw = 1'b1; a.req = 3'b001;
        step();
        outs("idle_to_scan", {a.grant, a.alarm, a.history, a.buzz}, 3'b000, 0, 0, 0);
        step();
        outs("first_grant", {a.grant, a.alarm, a.history, a.buzz}, 3'b001, 1, 0, 0);
        step();
        outs("show_hold", {a.grant, a.alarm, a.history, a.buzz}, 3'b001, 0, 0, 0);
        tick_a(3);
        outs("hold_3ticks", {a.grant, a.alarm, a.history, a.buzz}, 3'b001, 0, 0, 0);
        tick_a(1);
        outs("after_gap", {a.grant, a.alarm, a.history, a.buzz}, 3'b000, 0, 0, 0);
        step();
        outs("regrant_hist", {a.grant, a.alarm, a.history, a.buzz}, 3'b001, 1, 1, 1);
        step();
        outs("buzz_held", {a.grant, a.alarm, a.history, a.buzz}, 3'b001, 0, 0, 1);

        // acknowledge with coincident tick on the second SHOW cycle
        a.clear0 = 1'b1; a.tick = 1'b1;
        step();
        a.clear0 = 1'b0; a.tick = 1'b0;
        outs("clear_in_show", {a.grant, a.alarm, a.history, a.buzz}, 3'b000, 0, 0, 0);
        step();
        outs("gap_to_scan", {a.grant, a.alarm, a.history, a.buzz}, 3'b000, 0, 0, 0);
        a.req = 3'b000; a.clear0 = 1'b1;
        step();
        a.clear0 = 1'b0;
        outs("clear_in_scan", {a.grant, a.alarm, a.history, a.buzz}, 3'b000, 0, 0, 0);

        // all requests: round-robin continues at channel 1
        a.req = 3'b111;
        step();
        outs("rr_ch1", {a.grant, a.alarm, a.history, a.buzz}, 3'b010, 1, 0, 0);
        step();
        tick_a(3);
        outs("rr_ch1_hold", {a.grant, a.alarm, a.history, a.buzz}, 3'b010, 0, 0, 0);
        tick_a(1);
        outs("rr_ch1_end", {a.grant, a.alarm, a.history, a.buzz}, 3'b000, 0, 0, 0);
        step();
        outs("rr_ch2", {a.grant, a.alarm, a.history, a.buzz}, 3'b100, 1, 0, 0);
        step();
        tick_a(4);
        step();
        // channel 0 timer: 10 loaded, 8 ticks since -> still inside window
        outs("rr_ch0", {a.grant, a.alarm, a.history, a.buzz}, 3'b001, 1, 1, 1);

        // sw drop mid-SHOW clears pointer and timers
        step();
        a.sw = 1'b0;
        step();
        outs("sw_drop", {a.grant, a.alarm, a.history, a.buzz}, 3'b000, 0, 0, 0);
        a.sw = 1'b1; a.req = 3'b100;
        step();
        outs("sw_rise_scan", {a.grant, a.alarm, a.history, a.buzz}, 3'b000, 0, 0, 0);
        step();
        outs("sw_rise_grant", {a.grant, a.alarm, a.history, a.buzz}, 3'b100, 1, 0, 0);

        // reset mid-SHOW of a history grant
        step();
        tick_a(4);
        step();
        outs("rst_pre", {a.grant, a.alarm, a.history, a.buzz}, 3'b100, 1, 1, 1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        outs("rst_mid_show", {a.grant, a.alarm, a.history, a.buzz}, 3'b000, 0, 0, 0);
        step();
        step();
        outs("post_rst_grant", {a.grant, a.alarm, a.history, a.buzz}, 3'b100, 1, 0, 0);
        a.sw = 1'b0; a.req = 3'b000;

        // HIST_WIN=2 instance: window edges
        b.sw = 1'b1; b.req = 3'b010;
        step();
        step();
        outs("b_grant", {b.grant, b.alarm, b.history, b.buzz}, 3'b010, 1, 0, 0);
        b.req = 3'b000;
        step();
        tick_b(4);
        outs("b_end", {b.grant, b.alarm, b.history, b.buzz}, 3'b000, 0, 0, 0);
        tick_b(2);
        b.req = 3'b010;
        step();
        outs("b_hist_expired", {b.grant, b.alarm, b.history, b.buzz}, 3'b010, 1, 0, 0);
        b.req = 3'b000;
        step();
        tick_b(4);
        tick_b(1);
        b.req = 3'b010;
        step();
        outs("b_hist_live", {b.grant, b.alarm, b.history, b.buzz}, 3'b010, 1, 1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alarm_sched.md
ALARM_SCHED -- requirements
Module: alarm_sched

Interface
REQ-001 SHALL have parameter HOLD_TICKS, default 4, ticks a granted alarm is shown (legal 1..255).
REQ-002 SHALL have parameter HIST_WIN, default 10, ticks after a grant during which a re-alarm on the same channel counts as history (legal 1..255).
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port sw  input  1  post-op monitoring enable.
REQ-006 SHALL have port req  input  3  level alarm requests from the vital-sign checkers; bit 0 = heart rate, bit 1 = SpO2, bit 2 = temperature.
REQ-007 SHALL have port tick  input  1  one-cycle time-base strobe.
REQ-008 SHALL have port clear0  input  1  operator acknowledge.
REQ-009 SHALL have port grant  output  3  one-hot channel currently shown; all zero when none.
REQ-010 SHALL have port alarm  output  1  one-cycle pulse on each new grant; drives the alarm FSM.
REQ-011 SHALL have port history  output  1  one-cycle pulse, coincident with alarm, when the granted channel is inside its history window.
REQ-012 SHALL have port buzz  output  1  high for the whole SHOW period of a grant that raised history.

Function
REQ-013 SHALL implement the states IDLE, SCAN, SHOW and GAP, with all outputs registered.
REQ-014 IDLE: outputs 0; go to SCAN on the next edge when sw=1.
REQ-015 SCAN: if req is non-zero, select the winner per REQ-016, go to SHOW and assert grant, alarm and the history decision on the next edge; if req=0, stay in SCAN.
REQ-016 Arbitration SHALL be round-robin: search starts at pointer p (reset value 0), ascending with wrap 2->0; the first set bit wins.
REQ-017 SHOW: grant is held even if the winning req bit falls; the 8-bit hold counter starts at 0 and increments on each tick.
REQ-018 SHOW ends on the edge where tick=1 and the counter equals HOLD_TICKS-1, or on any edge where clear0=1; clear0 and tick in the same cycle act as clear0.
REQ-019 GAP lasts exactly one cycle with grant=0 and buzz=0; p becomes (winner+1) mod 3; the winner's window timer loads HIST_WIN; then go to SCAN.
REQ-020 Each channel SHALL have an 8-bit window timer that decrements on tick and saturates at 0; history is set for a grant exactly when that channel's timer is non-zero in the SCAN cycle.
REQ-021 A timer load in GAP SHALL take precedence over a tick decrement in the same cycle.
REQ-022 Minimum re-grant spacing SHALL be 3 cycles: SHOW end -> GAP -> SCAN -> SHOW.
REQ-023 sw=0 in any state SHALL force IDLE on the next edge: outputs go to 0, p resets to 0 and all timers clear.
REQ-024 clear0 outside SHOW SHALL be ignored.

Reset
REQ-025 rst=1 at a clock edge SHALL set state IDLE, grant=0, alarm=0, history=0, buzz=0, p=0, hold counter=0 and all window timers=0, overriding every other input.
REQ-026 Reset asserted mid-SHOW SHALL drop grant and buzz on that edge, with no GAP cycle and no timer load.

Configuration
REQ-027 With macro ALARM_SCHED_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority (bit 0 highest, then bit 1, then bit 2) and p SHALL be unused.
REQ-028 Without ALARM_SCHED_FIXED_PRIO_EN, arbitration SHALL be round-robin per REQ-016; all other behaviour is identical in both builds.

Verification
REQ-029 Reset, sw=1, req=3'b001 held, tick every 4 cycles -> grant=001 one cycle after SCAN, alarm pulse, history=0, grant held for 4 ticks, then GAP, SCAN, and a re-grant of 001 with history=1 and buzz=1.
REQ-030 req=3'b111 held, default parameters -> grants in order 001, 010, 100, 001 (round-robin), or 001 repeatedly with ALARM_SCHED_FIXED_PRIO_EN defined.
REQ-031 clear0=1 on the second cycle of SHOW together with tick -> GAP on the next edge and hold counter reset; clear0 pulsed in SCAN -> no effect.
REQ-032 HIST_WIN=2: grant ch1, then wait 2 ticks after GAP, then req=010 -> history=0 and buzz=0; with only 1 tick elapsed -> history=1.
REQ-033 sw falls mid-SHOW -> grant, buzz=0 on the next edge, state IDLE; sw rises with req=100 -> grant 100 (p was reset), history=0.
REQ-034 rst asserted mid-SHOW -> all outputs 0 on that edge, and after release no history on the next grant of the same channel.
